// File: rtl/cap1188_pkg.sv
// Shared constants and FSM encoding for the CAP1188 I2C target emulation.
`timescale 1ns/1ps
package cap1188_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR   = 7'h28;
  localparam logic [7:0] DEFAULT_PRODUCT_ID = 8'h50;
  localparam logic [7:0] DEFAULT_MFG_ID     = 8'h5D;
  localparam logic [7:0] DEFAULT_REVISION   = 8'h83;

  localparam logic [7:0] REG_MAIN_CTRL    = 8'h00;
  localparam logic [7:0] REG_INPUT_STATUS = 8'h03;
  localparam logic [7:0] REG_PRODUCT_ID   = 8'hFD;
  localparam logic [7:0] REG_MFG_ID       = 8'hFE;
  localparam logic [7:0] REG_REVISION     = 8'hFF;

  localparam int unsigned NUM_RW_REGS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-FF synchronizer for one I2C line; optional 3-sample stable filter
// when I2C_TGT_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module i2c_line_filter (
  input  logic clk_50,
  input  logic reset_n,
  input  logic line_in,
  output logic line_out
);

  // Idle I2C bus is high, so everything resets to 1.
  logic [1:0] sync;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) sync <= '1;
    else          sync <= {sync[0], line_in};
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] hist;
  logic       stable;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      hist   <= '1;
      stable <= 1'b1;
    end else begin
      hist <= {hist[1:0], sync[1]};
      if (hist == 3'b000 || hist == 3'b111) stable <= hist[0];
    end
  end

  assign line_out = stable;
`else
  assign line_out = sync[1];
`endif

endmodule

// File: rtl/cap1188_i2c_target.sv
// CAP1188 register-interface I2C target. Build option: I2C_TGT_GLITCH_FILTER_EN
// enables a 3-sample glitch filter on SCL/SDA inside i2c_line_filter.
`timescale 1ns/1ps
module cap1188_i2c_target
  import cap1188_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter logic [7:0] PRODUCT_ID = DEFAULT_PRODUCT_ID,
  parameter logic [7:0] MFG_ID     = DEFAULT_MFG_ID,
  parameter logic [7:0] REVISION   = DEFAULT_REVISION
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] touch_status,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] main_ctrl,
  output logic       busy
);

  logic scl_f, sda_f, scl_q, sda_q;

  i2c_line_filter u_scl_filter (.clk_50(clk_50), .reset_n(reset_n), .line_in(scl_in), .line_out(scl_f));
  i2c_line_filter u_sda_filter (.clk_50(clk_50), .reset_n(reset_n), .line_in(sda_in), .line_out(sda_f));

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  i2c_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic       rw;
  logic       first_byte;
  logic       ack_phase;
  logic [7:0] regs [NUM_RW_REGS];
  logic [7:0] rd_val;
  logic [7:0] byte_in;
  logic       wr_ok;

  assign byte_in   = {shreg[6:0], sda_f};
  assign wr_ok     = (ptr < 8'(NUM_RW_REGS)) && (ptr != REG_INPUT_STATUS);
  assign main_ctrl = regs[REG_MAIN_CTRL[3:0]];

  always_comb begin
    rd_val = '0;
    if (ptr < 8'(NUM_RW_REGS)) begin
      rd_val = (ptr == REG_INPUT_STATUS) ? touch_status : regs[ptr[3:0]];
    end else begin
      case (ptr)
        REG_PRODUCT_ID: rd_val = PRODUCT_ID;
        REG_MFG_ID:     rd_val = MFG_ID;
        REG_REVISION:   rd_val = REVISION;
        default:        rd_val = '0;
      endcase
    end
  end

  // ack_phase marks that the ACK bit is already on the bus, so the next
  // SCL fall is the 9th one and ends the acknowledge slot.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      ack_phase  <= 1'b0;
      sda_out    <= 1'b1;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      for (int unsigned i = 0; i < NUM_RW_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state     <= ST_IDLE;
        sda_out   <= 1'b1;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= ST_ADDR;
        sda_out   <= 1'b1;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                rw      <= sda_f;
                if (shreg[6:0] == DEV_ADDR) begin
                  state      <= ST_ADDR_ACK;
                  busy       <= 1'b1;
                  first_byte <= 1'b1;
                end else begin
                  state <= ST_IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_out   <= 1'b0;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (state == ST_ADDR_ACK && rw) begin
                  shreg   <= rd_val;
                  sda_out <= rd_val[7];
                  ptr     <= ptr + 8'd1;
                  state   <= ST_RD_BYTE;
                end else begin
                  sda_out <= 1'b1;
                  state   <= ST_WR_BYTE;
                end
              end
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                state   <= ST_WR_ACK;
                if (first_byte) begin
                  first_byte <= 1'b0;
                  ptr        <= byte_in;
                end else begin
                  if (wr_ok) regs[ptr[3:0]] <= byte_in;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= byte_in;
                  ptr       <= ptr + 8'd1;
                end
              end
            end
          end
          ST_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out <= 1'b1;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_out <= shreg[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              shreg     <= rd_val;
              sda_out   <= rd_val[7];
              ptr       <= ptr + 8'd1;
              state     <= ST_RD_BYTE;
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cap1188_i2c_target.sv
// Self-checking bench: bit-banged I2C initiator against a register-map model.
`timescale 1ns/1ps
module tb_cap1188_i2c_target;
  import cap1188_pkg::*;

  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_out, wr_strobe, busy;
  logic [7:0] touch_status = 8'h00;
  logic [7:0] wr_addr, wr_data, main_ctrl;

  assign sda_line = sda_m & sda_out;

  always #10 clk_50 = ~clk_50;

  cap1188_i2c_target dut (
    .clk_50(clk_50), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_line),
    .sda_out(sda_out), .touch_status(touch_status), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .main_ctrl(main_ctrl), .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int low_cnt = 0;
  int busy_cnt = 0;

  always @(posedge clk_50) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (sda_out === 1'b0)   low_cnt    <= low_cnt + 1;
    if (busy === 1'b1)      busy_cnt   <= busy_cnt + 1;
  end

  localparam int Q = 12;

  logic [7:0] mdl_regs [16];
  logic [7:0] rd_buf [4];
  logic [7:0] wr_buf [4];

  function automatic logic [7:0] mdl_val(input int a);
    if (a == 3) return touch_status;
    if (a < 16) return mdl_regs[a];
    case (a)
      'hFD:    return 8'h50;
      'hFE:    return 8'h5D;
      'hFF:    return 8'h83;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void mdl_write(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int a = (p + i) % 256;
      if (a < 16 && a != 3) mdl_regs[a] = wr_buf[i];
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl = 1'b1;   wait_cyc(2*Q);
    sda_m = 1'b0; wait_cyc(2*Q);
    scl = 1'b0;   wait_cyc(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl = 1'b1;   wait_cyc(2*Q);
    sda_m = 1'b1; wait_cyc(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;  wait_cyc(Q);
    scl = 1'b1; wait_cyc(2*Q);
    scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_cyc(Q);
    scl = 1'b1;   wait_cyc(Q);
    b = sda_line; wait_cyc(Q);
    scl = 1'b0;   wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = (b == 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic send_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(!send_ack);
  endtask

  task automatic write_regs(input logic [7:0] p, input int n, output logic ok);
    logic a;
    bus_start();
    write_byte(8'h50, a); ok = a;
    write_byte(p, a);     ok = ok & a;
    for (int i = 0; i < n; i++) begin
      write_byte(wr_buf[i], a);
      ok = ok & a;
    end
    bus_stop();
  endtask

  task automatic read_regs(input logic [7:0] p, input int n, output logic ok);
    logic a;
    logic [7:0] d;
    bus_start();
    write_byte(8'h50, a); ok = a;
    write_byte(p, a);     ok = ok & a;
    bus_start();
    write_byte(8'h51, a); ok = ok & a;
    for (int i = 0; i < n; i++) begin
      read_byte(d, i < n - 1);
      rd_buf[i] = d;
    end
    bus_stop();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(5);
    tests++; if (sda_out !== 1'b1) begin fails++; $display("FAIL reset_sda_out: got %b expected 1", sda_out); end
    tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    tests++; if (wr_addr !== 8'h00) begin fails++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    tests++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    tests++; if (main_ctrl !== 8'h00) begin fails++; $display("FAIL reset_main_ctrl: got %h expected 00", main_ctrl); end
    reset_n = 1'b1;
    wait_cyc(8);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (sda_out !== 1'b1) begin fails++; $display("FAIL post_reset_sda_out: got %b expected 1", sda_out); end
    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
  endtask

  task automatic test_id_read();
    logic a0, a1, a2, b0, b1;
    logic [7:0] d;
    bus_start();
    write_byte(8'h50, a0);
    write_byte(8'hFD, a1);
    bus_start();
    write_byte(8'h51, a2);
    b0 = busy;
    read_byte(d, 1'b0);
    b1 = busy;
    bus_stop();
    tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL id_acks: got %b expected 111", {a0, a1, a2}); end
    tests++; if (d !== mdl_val('hFD)) begin fails++; $display("FAIL id_product: got %h expected %h", d, mdl_val('hFD)); end
    tests++; if (b0 !== 1'b1) begin fails++; $display("FAIL id_busy_during: got %b expected 1", b0); end
    tests++; if (b1 !== 1'b0) begin fails++; $display("FAIL id_busy_after_nack: got %b expected 0", b1); end
  endtask

  task automatic test_write_main();
    int s;
    logic ok;
    s = strobe_cnt;
    wr_buf[0] = 8'hA5;
    write_regs(8'h00, 1, ok);
    mdl_write(0, 1);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL wm_acks: got %b expected 1", ok); end
    tests++; if (strobe_cnt - s !== 1) begin fails++; $display("FAIL wm_strobe_count: got %0d expected 1", strobe_cnt - s); end
    tests++; if (wr_addr !== 8'h00) begin fails++; $display("FAIL wm_wr_addr: got %h expected 00", wr_addr); end
    tests++; if (wr_data !== 8'hA5) begin fails++; $display("FAIL wm_wr_data: got %h expected a5", wr_data); end
    tests++; if (main_ctrl !== mdl_regs[0]) begin fails++; $display("FAIL wm_main_ctrl: got %h expected %h", main_ctrl, mdl_regs[0]); end
    read_regs(8'h00, 1, ok);
    tests++; if (rd_buf[0] !== mdl_val(0)) begin fails++; $display("FAIL wm_readback: got %h expected %h", rd_buf[0], mdl_val(0)); end
  endtask

  task automatic test_burst_id();
    logic ok;
    read_regs(8'hFD, 4, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL burst_acks: got %b expected 1", ok); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_buf[i] !== mdl_val((253 + i) % 256)) begin
        fails++; $display("FAIL burst_byte%0d: got %h expected %h", i, rd_buf[i], mdl_val((253 + i) % 256));
      end
    end
  endtask

  task automatic test_wrong_addr();
    int s, l, b;
    logic a0, a1;
    s = strobe_cnt; l = low_cnt; b = busy_cnt;
    bus_start();
    write_byte(8'h52, a0);
    write_byte(8'h00, a1);
    bus_stop();
    tests++; if (a0 !== 1'b0) begin fails++; $display("FAIL wrong_addr_ack: got %b expected 0", a0); end
    tests++; if (a1 !== 1'b0) begin fails++; $display("FAIL wrong_data_ack: got %b expected 0", a1); end
    tests++; if (low_cnt - l !== 0) begin fails++; $display("FAIL wrong_sda_low: got %0d expected 0", low_cnt - l); end
    tests++; if (strobe_cnt - s !== 0) begin fails++; $display("FAIL wrong_strobe: got %0d expected 0", strobe_cnt - s); end
    tests++; if (busy_cnt - b !== 0) begin fails++; $display("FAIL wrong_busy: got %0d expected 0", busy_cnt - b); end
  endtask

  task automatic test_touch();
    int s;
    logic ok;
    touch_status = 8'h12;
    read_regs(8'h03, 1, ok);
    tests++; if (rd_buf[0] !== 8'h12) begin fails++; $display("FAIL touch_read: got %h expected 12", rd_buf[0]); end
    s = strobe_cnt;
    wr_buf[0] = 8'hFF;
    write_regs(8'h03, 1, ok);
    mdl_write(3, 1);
    tests++; if (strobe_cnt - s !== 1) begin fails++; $display("FAIL touch_wr_strobe: got %0d expected 1", strobe_cnt - s); end
    tests++; if (wr_addr !== 8'h03) begin fails++; $display("FAIL touch_wr_addr: got %h expected 03", wr_addr); end
    read_regs(8'h03, 1, ok);
    tests++; if (rd_buf[0] !== mdl_val(3)) begin fails++; $display("FAIL touch_after_write: got %h expected %h", rd_buf[0], mdl_val(3)); end
  endtask

  task automatic test_random();
    int p, n, q, s, lp;
    logic ok;
    for (int it = 0; it < 8; it++) begin
      p = (it % 3 == 2) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wr_buf[i] = 8'($urandom_range(0, 255));
      touch_status = 8'($urandom_range(0, 255));
      s = strobe_cnt;
      write_regs(8'(p), n, ok);
      mdl_write(p, n);
      lp = (p + n - 1) % 256;
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rnd%0d_acks: got %b expected 1", it, ok); end
      tests++; if (strobe_cnt - s !== n) begin fails++; $display("FAIL rnd%0d_strobes: got %0d expected %0d", it, strobe_cnt - s, n); end
      tests++; if (wr_addr !== 8'(lp)) begin fails++; $display("FAIL rnd%0d_wr_addr: got %h expected %h", it, wr_addr, 8'(lp)); end
      tests++; if (wr_data !== wr_buf[n-1]) begin fails++; $display("FAIL rnd%0d_wr_data: got %h expected %h", it, wr_data, wr_buf[n-1]); end
      tests++; if (main_ctrl !== mdl_regs[0]) begin fails++; $display("FAIL rnd%0d_main_ctrl: got %h expected %h", it, main_ctrl, mdl_regs[0]); end
      q = (it % 4 == 3) ? $urandom_range(250, 255) : $urandom_range(0, 15);
      read_regs(8'(q), 4, ok);
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rd_buf[i] !== mdl_val((q + i) % 256)) begin
          fails++; $display("FAIL rnd%0d_read%0d: got %h expected %h", it, i, rd_buf[i], mdl_val((q + i) % 256));
        end
      end
    end
  endtask

  task automatic test_stop_midbyte();
    int s;
    logic a;
    bus_start();
    write_byte(8'h50, a);
    write_byte(8'h05, a);
    s = strobe_cnt;
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    bus_stop();
    wait_cyc(4);
    tests++; if (strobe_cnt - s !== 0) begin fails++; $display("FAIL stop_mid_strobe: got %0d expected 0", strobe_cnt - s); end
    tests++; if (sda_out !== 1'b1) begin fails++; $display("FAIL stop_mid_sda_out: got %b expected 1", sda_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_mid_busy: got %b expected 0", busy); end
    tests++; if (dut.state !== ST_IDLE) begin fails++; $display("FAIL stop_mid_state: got %0d expected %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic ok;
    logic [7:0] addr_w;
    addr_w = 8'h50;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
    sda_m = 1'b1;
    k = 0;
    while (sda_out !== 1'b0 && k < 40) begin
      wait_cyc(1);
      k++;
    end
    tests++; if (sda_out !== 1'b0) begin fails++; $display("FAIL rstmid_ack_driven: got %b expected 0", sda_out); end
    reset_n = 1'b0;
    #1;
    tests++; if (sda_out !== 1'b1) begin fails++; $display("FAIL rstmid_sda_out: got %b expected 1", sda_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tests++; if (main_ctrl !== 8'h00) begin fails++; $display("FAIL rstmid_main_ctrl: got %h expected 00", main_ctrl); end
    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(6);
    bus_stop();
    read_regs(8'h00, 2, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rstmid_post_acks: got %b expected 1", ok); end
    tests++; if (rd_buf[1] !== mdl_val(1)) begin fails++; $display("FAIL rstmid_post_read: got %h expected %h", rd_buf[1], mdl_val(1)); end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_write_main();
    test_burst_id();
    test_wrong_addr();
    test_touch();
    test_random();
    test_stop_midbyte();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
